// File: rtl/maquina_control_seq_pkg.sv
// Shared definitions for the MaquinaSencilla control/sequencing stage:
// ISA opcodes, ALU operation codes, FSM state encoding and the opcode-to-ALU mapping.
package maquina_control_seq_pkg;

   localparam int unsigned DEF_DATA_W = 16;
   localparam int unsigned DEF_ADDR_W = 7;
   localparam int unsigned OP_W       = 2;

   typedef enum logic [1:0] {
      OP_ADD = 2'd0,
      OP_CMP = 2'd1,
      OP_MOV = 2'd2,
      OP_BEQ = 2'd3
   } opcode_e;

   typedef enum logic [1:0] {
      ALU_ADD   = 2'd0,
      ALU_XOR   = 2'd1,
      ALU_PASSB = 2'd2,
      ALU_NOT   = 2'd3
   } alu_op_e;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_RD_SRC = 3'd2,
      ST_RD_DST = 3'd3,
      ST_EXEC   = 3'd4,
      ST_WRITE  = 3'd5
   } state_e;

   // CMP is evaluated as XOR so the ALU zero flag means "operands equal".
   function automatic alu_op_e alu_op_for(input opcode_e op);
      case (op)
         OP_ADD:  return ALU_ADD;
         OP_CMP:  return ALU_XOR;
         default: return ALU_PASSB;
      endcase
   endfunction

endpackage

// File: rtl/maquina_control_seq.sv
// Fetch/operand-read/execute/write-back sequencer feeding an external 16-bit ALU.
// Memory and IO share one req/ack word port; request outputs are Moore decodes of state.
module maquina_control_seq
   import maquina_control_seq_pkg::*;
#(
   parameter int unsigned DATA_W   = DEF_DATA_W,
   parameter int unsigned ADDR_W   = DEF_ADDR_W,
   parameter int unsigned RESET_PC = 0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              run,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ack,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   output logic [1:0]        alu_op,
   input  logic [DATA_W-1:0] alu_out,
   input  logic              alu_z,
   output logic [ADDR_W-1:0] pc,
   output logic              zflag,
   output logic              instr_done
);

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   pc_q, pc_d;
   logic                z_q, z_d;
   logic [DATA_W-1:0]   ir_q, ir_d;
   logic [DATA_W-1:0]   a_q, a_d;
   logic [DATA_W-1:0]   b_q, b_d;
   logic [DATA_W-1:0]   r_q, r_d;
   logic                done_q, done_d;
   logic                retire;

   opcode_e             ir_op, rd_op;
   logic [ADDR_W-1:0]   ir_src, ir_dst, rd_dst;

   // Field slices of the latched instruction and of the word arriving during FETCH.
   assign ir_op  = opcode_e'(ir_q[DATA_W-1 -: OP_W]);
   assign ir_src = ir_q[2*ADDR_W-1 -: ADDR_W];
   assign ir_dst = ir_q[ADDR_W-1:0];
   assign rd_op  = opcode_e'(mem_rdata[DATA_W-1 -: OP_W]);
   assign rd_dst = mem_rdata[ADDR_W-1:0];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         pc_q    <= ADDR_W'(RESET_PC);
         z_q     <= 1'b0;
         ir_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         r_q     <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         z_q     <= z_d;
         ir_q    <= ir_d;
         a_q     <= a_d;
         b_q     <= b_d;
         r_q     <= r_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      z_d     = z_q;
      ir_d    = ir_q;
      a_d     = a_q;
      b_d     = b_q;
      r_d     = r_q;
      done_d  = 1'b0;
      retire  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (run) state_d = ST_FETCH;
         end
         ST_FETCH: begin
            if (mem_ack) begin
               ir_d = mem_rdata;
               pc_d = pc_q + ADDR_W'(1);
               if (rd_op == OP_BEQ) begin
                  if (z_q) pc_d = rd_dst;
                  retire = 1'b1;
               end else begin
                  state_d = ST_RD_SRC;
               end
            end
         end
         ST_RD_SRC: begin
            if (mem_ack) begin
               b_d     = mem_rdata;
               state_d = (ir_op == OP_MOV) ? ST_EXEC : ST_RD_DST;
            end
         end
         ST_RD_DST: begin
            if (mem_ack) begin
               a_d     = mem_rdata;
               state_d = ST_EXEC;
            end
         end
         ST_EXEC: begin
            r_d = alu_out;
            z_d = alu_z;
            if (ir_op == OP_CMP) retire = 1'b1;
            else                 state_d = ST_WRITE;
         end
         ST_WRITE: begin
            if (mem_ack) retire = 1'b1;
         end
         default: state_d = ST_IDLE;
      endcase

      // run is only consulted at the instruction boundary.
      if (retire) begin
         done_d  = 1'b1;
         state_d = run ? ST_FETCH : ST_IDLE;
      end
   end

   always_comb begin
      mem_req  = 1'b0;
      mem_we   = 1'b0;
      mem_addr = '0;
      alu_op   = ALU_PASSB;
      case (state_q)
         ST_FETCH: begin
            mem_req  = 1'b1;
            mem_addr = pc_q;
         end
         ST_RD_SRC: begin
            mem_req  = 1'b1;
            mem_addr = ir_src;
         end
         ST_RD_DST: begin
            mem_req  = 1'b1;
            mem_addr = ir_dst;
         end
         ST_EXEC: begin
            alu_op = alu_op_for(ir_op);
         end
         ST_WRITE: begin
            mem_req  = 1'b1;
            mem_we   = 1'b1;
            mem_addr = ir_dst;
         end
         default: ;
      endcase
   end

   assign mem_wdata  = r_q;
   assign alu_a      = a_q;
   assign alu_b      = b_q;
   assign pc         = pc_q;
   assign zflag      = z_q;
   assign instr_done = done_q;

endmodule

// File: tb/tb_maquina_control_seq.sv
// Directed bench for maquina_control_seq: word memory with programmable ack latency,
// behavioural ALU, a table of single-instruction vectors and hand-written corner sequences.
module tb_maquina_control_seq;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        run = 1'b0;
   logic        mem_req, mem_we, mem_ack;
   logic [6:0]  mem_addr;
   logic [15:0] mem_wdata, mem_rdata;
   logic [15:0] alu_a, alu_b, alu_out;
   logic [1:0]  alu_op;
   logic        alu_z;
   logic [6:0]  pc;
   logic        zflag, instr_done;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   maquina_control_seq #(.DATA_W(16), .ADDR_W(7), .RESET_PC(0)) dut (
      .clk(clk), .reset(reset), .run(run),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
      .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
      .alu_out(alu_out), .alu_z(alu_z),
      .pc(pc), .zflag(zflag), .instr_done(instr_done)
   );

   // External ALU: 0 ADD, 1 XOR, 2 pass B, 3 NOT A.
   always_comb begin
      case (alu_op)
         2'd0:    alu_out = alu_a + alu_b;
         2'd1:    alu_out = alu_a ^ alu_b;
         2'd2:    alu_out = alu_b;
         default: alu_out = ~alu_a;
      endcase
      alu_z = (alu_out == 16'h0000);
   end

   // Word memory: ack after ack_delay waiting cycles; spur drives ack while no request.
   logic [15:0] mem [0:127];
   int ack_delay = 0;
   int wcnt = 0;
   bit spur = 1'b0;
   int n_writes = 0;

   assign mem_rdata = mem[mem_addr];
   always_comb mem_ack = mem_req ? (wcnt >= ack_delay) : spur;

   always @(posedge clk) begin
      if (mem_req && mem_ack) begin
         if (mem_we) begin
            mem[mem_addr] = mem_wdata;
            n_writes      = n_writes + 1;
         end
         wcnt <= 0;
      end else if (mem_req) begin
         wcnt <= wcnt + 1;
      end else begin
         wcnt <= 0;
      end
   end

   // Request outputs must hold while a request waits for ack.
   bit          p_wait = 1'b0;
   logic [6:0]  p_addr;
   logic        p_we;
   logic [15:0] p_wdata;
   int          n_unstable = 0;
   int          n_we_obs = 0;

   always @(negedge clk) begin
      if (p_wait && !reset &&
          (!mem_req || mem_addr != p_addr || mem_we != p_we || (mem_we && mem_wdata != p_wdata)))
         n_unstable = n_unstable + 1;
      if (mem_req && mem_we) n_we_obs = n_we_obs + 1;
      p_wait  = mem_req && !mem_ack && !reset;
      p_addr  = mem_addr;
      p_we    = mem_we;
      p_wdata = mem_wdata;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests = n_tests + 1;
      if (act !== exp) begin
         n_fail = n_fail + 1;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Counts edges (sampling 1 time unit after each) until instr_done is seen.
   task automatic wait_done(input string name, input int budget, output int cyc);
      cyc = 0;
      do begin
         @(posedge clk);
         #1;
         cyc = cyc + 1;
      end while (!instr_done && cyc < budget);
      if (!instr_done) begin
         n_tests = n_tests + 1;
         n_fail  = n_fail + 1;
         $display("FAIL %s: no instr_done within %0d cycles", name, budget);
      end
   endtask

   function automatic logic [15:0] mk(input int op, input int src, input int dst);
      return {2'(op), 7'(src), 7'(dst)};
   endfunction

   task automatic clear_mem();
      for (int i = 0; i < 128; i++) mem[i] = 16'h0000;
   endtask

   task automatic release_and_start();
      @(negedge clk);
      reset = 1'b0;
      run   = 1'b1;
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic [15:0] instr;
      logic [6:0]  at;
      int          cyc;
      logic [6:0]  pc;
      logic        z;
      logic [6:0]  chk_addr;
      logic [15:0] chk_val;
      int          writes;
   } vec_t;

   localparam int ADD = 0, CMP = 1, MOV = 2, BEQ = 3;
   localparam int NV = 11;

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : main
      vec_t vecs[NV];
      int cyc, w0, we0, busy;

      vecs[0]  = '{mk(ADD, 10, 11), 7'd0,  5, 7'd1,  1'b0, 7'd11, 16'h0007, 1};
      vecs[1]  = '{mk(CMP, 12, 13), 7'd1,  4, 7'd2,  1'b1, 7'd13, 16'hA5A5, 0};
      vecs[2]  = '{mk(BEQ, 0, 40),  7'd2,  1, 7'd40, 1'b1, 7'd13, 16'hA5A5, 0};
      vecs[3]  = '{mk(CMP, 14, 15), 7'd40, 4, 7'd41, 1'b0, 7'd15, 16'h0002, 0};
      vecs[4]  = '{mk(BEQ, 0, 0),   7'd41, 1, 7'd42, 1'b0, 7'd15, 16'h0002, 0};
      vecs[5]  = '{mk(ADD, 16, 17), 7'd42, 5, 7'd43, 1'b1, 7'd17, 16'h0000, 1};
      vecs[6]  = '{mk(MOV, 18, 19), 7'd43, 4, 7'd44, 1'b0, 7'd19, 16'h8001, 1};
      vecs[7]  = '{mk(MOV, 20, 21), 7'd44, 4, 7'd45, 1'b1, 7'd21, 16'h0000, 1};
      vecs[8]  = '{mk(BEQ, 0, 50),  7'd45, 1, 7'd50, 1'b1, 7'd21, 16'h0000, 0};
      vecs[9]  = '{mk(ADD, 22, 23), 7'd50, 5, 7'd51, 1'b0, 7'd23, 16'h5555, 1};
      vecs[10] = '{mk(ADD, 23, 23), 7'd51, 5, 7'd52, 1'b0, 7'd23, 16'hAAAA, 1};

      // Asynchronous reset before any clock edge.
      #1 reset = 1'b1;
      #1;
      chk("rst_mem_req",  mem_req, 0);
      chk("rst_mem_we",   mem_we, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_alu_op",   alu_op, 2);
      chk("rst_pc",       pc, 0);
      chk("rst_zflag",    zflag, 0);
      chk("rst_done",     instr_done, 0);

      // Table-driven program, zero wait states.
      clear_mem();
      mem[10] = 16'h0003; mem[11] = 16'h0004;
      mem[12] = 16'hA5A5; mem[13] = 16'hA5A5;
      mem[14] = 16'h0001; mem[15] = 16'h0002;
      mem[16] = 16'hFFFF; mem[17] = 16'h0001;
      mem[18] = 16'h8001; mem[19] = 16'h0000;
      mem[20] = 16'h0000; mem[21] = 16'h1234;
      mem[22] = 16'h1234; mem[23] = 16'h4321;
      for (int i = 0; i < NV; i++) mem[vecs[i].at] = vecs[i].instr;
      ack_delay = 0;
      spur      = 1'b0;
      release_and_start();
      for (int i = 0; i < NV; i++) begin
         w0  = n_writes;
         we0 = n_we_obs;
         wait_done($sformatf("v%0d_done", i), 40, cyc);
         chk($sformatf("v%0d_cycles", i), cyc, vecs[i].cyc);
         chk($sformatf("v%0d_pc", i), pc, vecs[i].pc);
         chk($sformatf("v%0d_zflag", i), zflag, vecs[i].z);
         chk($sformatf("v%0d_mem", i), mem[vecs[i].chk_addr], vecs[i].chk_val);
         chk($sformatf("v%0d_writes", i), n_writes - w0, vecs[i].writes);
         chk($sformatf("v%0d_we_cycles", i), n_we_obs - we0, vecs[i].writes);
      end

      // ADD with 3 wait cycles per access and ack held high while no request.
      reset = 1'b1;
      run   = 1'b0;
      clear_mem();
      mem[0]  = mk(ADD, 10, 11);
      mem[10] = 16'h0003;
      mem[11] = 16'h0004;
      ack_delay  = 3;
      spur       = 1'b1;
      n_unstable = 0;
      release_and_start();
      wait_done("slow_done", 60, cyc);
      chk("slow_cycles",   cyc, 17);
      chk("slow_result",   mem[11], 16'h0007);
      chk("slow_zflag",    zflag, 0);
      chk("slow_pc",       pc, 1);
      chk("slow_stable",   n_unstable, 0);

      // pc wrap at 127 and run dropped during RD_DST.
      reset = 1'b1;
      run   = 1'b0;
      clear_mem();
      mem[0]   = mk(CMP, 10, 10);
      mem[1]   = mk(BEQ, 0, 127);
      mem[127] = mk(ADD, 10, 11);
      mem[10]  = 16'h0005;
      mem[11]  = 16'h0006;
      ack_delay = 0;
      spur      = 1'b0;
      release_and_start();
      wait_done("wrap_cmp", 20, cyc);
      chk("wrap_cmp_z", zflag, 1);
      wait_done("wrap_beq", 20, cyc);
      chk("wrap_beq_pc", pc, 127);
      @(posedge clk); #1;
      @(posedge clk); #1;
      run = 1'b0;
      wait_done("wrap_add", 20, cyc);
      chk("wrap_add_rest", cyc, 3);
      chk("wrap_pc",       pc, 0);
      chk("wrap_result",   mem[11], 16'h000B);
      chk("wrap_zflag",    zflag, 0);
      busy = 0;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         if (mem_req || instr_done) busy = busy + 1;
      end
      chk("idle_quiet", busy, 0);
      chk("idle_pc",    pc, 0);

      // Reset while WRITE waits for ack.
      reset = 1'b1;
      clear_mem();
      mem[0]  = mk(MOV, 10, 11);
      mem[10] = 16'h0000;
      mem[11] = 16'h1234;
      ack_delay = 5;
      release_and_start();
      cyc = 0;
      while (!(mem_req && mem_we) && cyc < 60) begin
         @(posedge clk); #1;
         cyc = cyc + 1;
      end
      chk("wr_wait_seen", mem_req && mem_we, 1);
      chk("wr_wait_z",    zflag, 1);
      w0 = n_writes;
      #2 reset = 1'b1;
      #1;
      chk("rst_async_req",  mem_req, 0);
      chk("rst_async_we",   mem_we, 0);
      chk("rst_async_pc",   pc, 0);
      chk("rst_async_z",    zflag, 0);
      chk("rst_async_done", instr_done, 0);
      run = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      chk("rst_no_write", n_writes - w0, 0);
      chk("rst_mem_kept", mem[11], 16'h1234);
      chk("rst_idle_req", mem_req, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
